// File: rtl/reorder_buffer_pkg.sv
// Shared types and default widths for the reorder buffer.
`ifndef ARCH_REG_NUM_WIDTH
`define ARCH_REG_NUM_WIDTH 5
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif

package reorder_buffer_pkg;

  localparam int unsigned ROB_DEPTH_WIDTH_DEF = 4;
  localparam int unsigned ARCH_REG_W          = `ARCH_REG_NUM_WIDTH;
  localparam int unsigned PHY_REG_W           = `PHYSICAL_REG_NUM_WIDTH;

  typedef struct packed {
    logic                 valid;
    logic                 done;
    logic                 with_write;
    logic [PHY_REG_W-1:0]  phy_wr_reg;
    logic [ARCH_REG_W-1:0] arch_wr_reg;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_rob_ptr.sv
// Circular-buffer pointer with an extra wrap bit; clear has priority over increment.
module rob_ptr #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W:0]   ptr
);

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + (W+1)'(1);
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit buffer: allocate at tail, mark done on writeback, retire oldest done entry.
// Optional ROB_FLUSH_EN adds a flush input that empties the buffer.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned ROB_DEPTH_WIDTH        = ROB_DEPTH_WIDTH_DEF,
  parameter int unsigned ARCH_REG_NUM_WIDTH     = ARCH_REG_W,
  parameter int unsigned PHYSICAL_REG_NUM_WIDTH = PHY_REG_W
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              alloc_valid,
  input  logic                              alloc_with_write,
  input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_phy_wr_reg,
  input  logic [ARCH_REG_NUM_WIDTH-1:0]     alloc_arch_wr_reg,
  output logic                              alloc_ready,
  output logic [ROB_DEPTH_WIDTH-1:0]        alloc_rob_id,
  input  logic                              wb_valid,
  input  logic [ROB_DEPTH_WIDTH-1:0]        wb_rob_id,
  output logic                              commit_valid,
  output logic                              commit_with_write,
  output logic [PHYSICAL_REG_NUM_WIDTH-1:0] commited_wr_register,
  output logic [ARCH_REG_NUM_WIDTH-1:0]     commit_arch_wr_reg,
  output logic [ROB_DEPTH_WIDTH:0]          count,
  output logic                              empty,
  output logic                              full
`ifdef ROB_FLUSH_EN
  ,
  input  logic                              flush
`endif
);

  localparam int unsigned DEPTH = 1 << ROB_DEPTH_WIDTH;

  logic [ROB_DEPTH_WIDTH:0]   head, tail;
  logic [ROB_DEPTH_WIDTH-1:0] head_idx, tail_idx;
  logic                       flush_now;
  logic                       alloc_fire;
  rob_entry_t                 entries [DEPTH];
  rob_entry_t                 head_entry;

`ifdef ROB_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  rob_ptr #(.W(ROB_DEPTH_WIDTH)) u_head (
    .clk   (clk),
    .reset (reset),
    .inc   (commit_valid),
    .clr   (flush_now),
    .ptr   (head)
  );

  rob_ptr #(.W(ROB_DEPTH_WIDTH)) u_tail (
    .clk   (clk),
    .reset (reset),
    .inc   (alloc_fire),
    .clr   (flush_now),
    .ptr   (tail)
  );

  // Occupancy and commit status, all derived from registered state.
  assign head_idx     = head[ROB_DEPTH_WIDTH-1:0];
  assign tail_idx     = tail[ROB_DEPTH_WIDTH-1:0];
  assign empty        = (head == tail);
  assign full         = (head_idx == tail_idx) && (head[ROB_DEPTH_WIDTH] != tail[ROB_DEPTH_WIDTH]);
  assign count        = tail - head;
  assign alloc_ready  = !full;
  assign alloc_rob_id = tail_idx;
  assign alloc_fire   = alloc_valid && !full && !flush_now;
  assign head_entry   = entries[head_idx];
  assign commit_valid = head_entry.valid && head_entry.done && !flush_now;

  assign commit_with_write    = commit_valid ? head_entry.with_write : 1'b0;
  assign commited_wr_register = commit_valid ? PHYSICAL_REG_NUM_WIDTH'(head_entry.phy_wr_reg) : '0;
  assign commit_arch_wr_reg   = commit_valid ? ARCH_REG_NUM_WIDTH'(head_entry.arch_wr_reg) : '0;

  // Writeback, then commit clear, then allocation; alloc never targets the committing slot.
  always_ff @(posedge clk) begin
    if (!reset || flush_now) begin
      entries <= '{default: '0};
    end else begin
      if (wb_valid && entries[wb_rob_id].valid) begin
        entries[wb_rob_id].done <= 1'b1;
      end
      if (commit_valid) begin
        entries[head_idx] <= '0;
      end
      if (alloc_fire) begin
        entries[tail_idx] <= '{
          valid:       1'b1,
          done:        1'b0,
          with_write:  alloc_with_write,
          phy_wr_reg:  PHY_REG_W'(alloc_phy_wr_reg),
          arch_wr_reg: ARCH_REG_W'(alloc_arch_wr_reg)
        };
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer; flush scenario runs when ROB_FLUSH_EN is defined.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int unsigned DW = ROB_DEPTH_WIDTH_DEF;

  logic                  clk;
  logic                  reset;
  logic                  alloc_valid;
  logic                  alloc_with_write;
  logic [PHY_REG_W-1:0]  alloc_phy_wr_reg;
  logic [ARCH_REG_W-1:0] alloc_arch_wr_reg;
  logic                  alloc_ready;
  logic [DW-1:0]         alloc_rob_id;
  logic                  wb_valid;
  logic [DW-1:0]         wb_rob_id;
  logic                  commit_valid;
  logic                  commit_with_write;
  logic [PHY_REG_W-1:0]  commited_wr_register;
  logic [ARCH_REG_W-1:0] commit_arch_wr_reg;
  logic [DW:0]           count;
  logic                  empty;
  logic                  full;
`ifdef ROB_FLUSH_EN
  logic                  flush;
`endif

  int checks = 0;
  int errors = 0;

  reorder_buffer dut (
    .clk                  (clk),
    .reset                (reset),
    .alloc_valid          (alloc_valid),
    .alloc_with_write     (alloc_with_write),
    .alloc_phy_wr_reg     (alloc_phy_wr_reg),
    .alloc_arch_wr_reg    (alloc_arch_wr_reg),
    .alloc_ready          (alloc_ready),
    .alloc_rob_id         (alloc_rob_id),
    .wb_valid             (wb_valid),
    .wb_rob_id            (wb_rob_id),
    .commit_valid         (commit_valid),
    .commit_with_write    (commit_with_write),
    .commited_wr_register (commited_wr_register),
    .commit_arch_wr_reg   (commit_arch_wr_reg),
    .count                (count),
    .empty                (empty),
    .full                 (full)
`ifdef ROB_FLUSH_EN
    ,
    .flush                (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    alloc_valid       = 1'b0;
    alloc_with_write  = 1'b0;
    alloc_phy_wr_reg  = '0;
    alloc_arch_wr_reg = '0;
    wb_valid          = 1'b0;
    wb_rob_id         = '0;
`ifdef ROB_FLUSH_EN
    flush             = 1'b0;
`endif
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (empty !== 1'b1 || count !== 5'd0 || alloc_ready !== 1'b1 || commit_valid !== 1'b0 ||
          alloc_rob_id !== 4'd0 || full !== 1'b0 || commited_wr_register !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d: empty=%b count=%0d ready=%b cv=%b id=%0d full=%b reg=%0d, need 1 0 1 0 0 0 0",
                 i, empty, count, alloc_ready, commit_valid, alloc_rob_id, full, commited_wr_register);
      end
      tick();
    end
  endtask

  task automatic test_single();
    apply_reset();
    alloc_valid = 1'b1; alloc_with_write = 1'b1;
    alloc_phy_wr_reg = 6'd40; alloc_arch_wr_reg = 5'd5;
    checks++;
    if (alloc_rob_id !== 4'd0) begin
      errors++; $display("FAIL single_id: got %0d need 0", alloc_rob_id);
    end
    tick();
    alloc_valid = 1'b0; wb_valid = 1'b1; wb_rob_id = 4'd0;
    checks++;
    if (count !== 5'd1 || commit_valid !== 1'b0) begin
      errors++; $display("FAIL single_alloc: count=%0d cv=%b need 1 0", count, commit_valid);
    end
    tick();
    wb_valid = 1'b0;
    checks++;
    if (commit_valid !== 1'b1 || commited_wr_register !== 6'd40 || commit_arch_wr_reg !== 5'd5 ||
        commit_with_write !== 1'b1) begin
      errors++;
      $display("FAIL single_commit: cv=%b reg=%0d arch=%0d ww=%b need 1 40 5 1",
               commit_valid, commited_wr_register, commit_arch_wr_reg, commit_with_write);
    end
    tick();
    checks++;
    if (empty !== 1'b1 || commit_valid !== 1'b0 || commited_wr_register !== 6'd0 ||
        commit_arch_wr_reg !== 5'd0 || commit_with_write !== 1'b0) begin
      errors++;
      $display("FAIL single_after: empty=%b cv=%b reg=%0d arch=%0d ww=%b need 1 0 0 0 0",
               empty, commit_valid, commited_wr_register, commit_arch_wr_reg, commit_with_write);
    end
  endtask

  task automatic test_out_of_order();
    logic [PHY_REG_W-1:0] exp_phy [3] = '{6'd10, 6'd11, 6'd12};
    logic [ARCH_REG_W-1:0] exp_arch [3] = '{5'd1, 5'd2, 5'd3};
    logic exp_ww [3] = '{1'b1, 1'b0, 1'b1};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_with_write = exp_ww[i];
      alloc_phy_wr_reg = exp_phy[i]; alloc_arch_wr_reg = exp_arch[i];
      checks++;
      if (alloc_rob_id !== 4'(i)) begin
        errors++; $display("FAIL ooo_id: got %0d need %0d", alloc_rob_id, i);
      end
      tick();
    end
    alloc_valid = 1'b0;
    for (int k = 2; k >= 1; k--) begin
      wb_valid = 1'b1; wb_rob_id = 4'(k);
      tick();
      checks++;
      if (commit_valid !== 1'b0) begin
        errors++; $display("FAIL ooo_early_commit: after wb %0d cv=%b need 0", k, commit_valid);
      end
    end
    wb_rob_id = 4'd0;
    tick();
    wb_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (commit_valid !== 1'b1 || commited_wr_register !== exp_phy[i] ||
          commit_arch_wr_reg !== exp_arch[i] || commit_with_write !== exp_ww[i]) begin
        errors++;
        $display("FAIL ooo_commit%0d: cv=%b reg=%0d arch=%0d ww=%b need 1 %0d %0d %b",
                 i, commit_valid, commited_wr_register, commit_arch_wr_reg, commit_with_write,
                 exp_phy[i], exp_arch[i], exp_ww[i]);
      end
      tick();
    end
    checks++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      errors++; $display("FAIL ooo_drain: empty=%b count=%0d need 1 0", empty, count);
    end
  endtask

  task automatic test_wb_same_cycle();
    apply_reset();
    alloc_valid = 1'b1; alloc_with_write = 1'b1;
    alloc_phy_wr_reg = 6'd7; alloc_arch_wr_reg = 5'd9;
    wb_valid = 1'b1; wb_rob_id = 4'd0;
    tick();
    alloc_valid = 1'b0; wb_rob_id = 4'd3;
    tick();
    wb_valid = 1'b0;
    checks++;
    if (count !== 5'd1 || commit_valid !== 1'b0) begin
      errors++; $display("FAIL wb_ignored: count=%0d cv=%b need 1 0", count, commit_valid);
    end
    wb_valid = 1'b1; wb_rob_id = 4'd0;
    tick();
    wb_valid = 1'b0;
    checks++;
    if (commit_valid !== 1'b1 || commited_wr_register !== 6'd7) begin
      errors++; $display("FAIL wb_late_commit: cv=%b reg=%0d need 1 7", commit_valid, commited_wr_register);
    end
  endtask

  task automatic test_fill_wrap();
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      alloc_valid = 1'b1; alloc_with_write = 1'b1;
      alloc_phy_wr_reg = 6'(i + 16); alloc_arch_wr_reg = 5'(i);
      checks++;
      if (alloc_rob_id !== 4'(i)) begin
        errors++; $display("FAIL fill_id: got %0d need %0d", alloc_rob_id, i);
      end
      tick();
    end
    checks++;
    if (full !== 1'b1 || alloc_ready !== 1'b0 || count !== 5'd16 || empty !== 1'b0) begin
      errors++; $display("FAIL fill_full: full=%b ready=%b count=%0d empty=%b need 1 0 16 0",
                         full, alloc_ready, count, empty);
    end
    alloc_phy_wr_reg = 6'd63; alloc_arch_wr_reg = 5'd31;
    tick();
    alloc_valid = 1'b0;
    checks++;
    if (count !== 5'd16 || commit_valid !== 1'b0) begin
      errors++; $display("FAIL fill_drop: count=%0d cv=%b need 16 0", count, commit_valid);
    end
    for (int i = 0; i < 16; i++) begin
      wb_valid = 1'b1; wb_rob_id = 4'(i);
      tick();
      checks++;
      if (commit_valid !== 1'b1 || commited_wr_register !== 6'(i + 16) || commit_arch_wr_reg !== 5'(i)) begin
        errors++; $display("FAIL fill_commit%0d: cv=%b reg=%0d arch=%0d need 1 %0d %0d",
                           i, commit_valid, commited_wr_register, commit_arch_wr_reg, i + 16, i);
      end
    end
    wb_valid = 1'b0;
    tick();
    checks++;
    if (empty !== 1'b1 || count !== 5'd0 || alloc_rob_id !== 4'd0 || commit_valid !== 1'b0) begin
      errors++; $display("FAIL fill_wrap: empty=%b count=%0d id=%0d cv=%b need 1 0 0 0",
                         empty, count, alloc_rob_id, commit_valid);
    end
  endtask

  task automatic test_full_commit();
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      alloc_valid = 1'b1; alloc_with_write = 1'b0;
      alloc_phy_wr_reg = 6'(i); alloc_arch_wr_reg = 5'(i);
      tick();
    end
    alloc_valid = 1'b0; wb_valid = 1'b1; wb_rob_id = 4'd0;
    tick();
    wb_valid = 1'b0;
    alloc_valid = 1'b1; alloc_with_write = 1'b1;
    alloc_phy_wr_reg = 6'd50; alloc_arch_wr_reg = 5'd7;
    checks++;
    if (full !== 1'b1 || alloc_ready !== 1'b0 || commit_valid !== 1'b1 || commited_wr_register !== 6'd0) begin
      errors++; $display("FAIL full_pre: full=%b ready=%b cv=%b reg=%0d need 1 0 1 0",
                         full, alloc_ready, commit_valid, commited_wr_register);
    end
    tick();
    checks++;
    if (count !== 5'd15 || alloc_ready !== 1'b1 || alloc_rob_id !== 4'd0) begin
      errors++; $display("FAIL full_blocked: count=%0d ready=%b id=%0d need 15 1 0",
                         count, alloc_ready, alloc_rob_id);
    end
    tick();
    alloc_valid = 1'b0;
    checks++;
    if (count !== 5'd16 || full !== 1'b1 || alloc_rob_id !== 4'd1) begin
      errors++; $display("FAIL full_accept: count=%0d full=%b id=%0d need 16 1 1", count, full, alloc_rob_id);
    end
  endtask

`ifdef ROB_FLUSH_EN
  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1'b1; alloc_with_write = 1'b1;
      alloc_phy_wr_reg = 6'(i + 1); alloc_arch_wr_reg = 5'(i);
      tick();
    end
    alloc_valid = 1'b0; wb_valid = 1'b1; wb_rob_id = 4'd0;
    tick();
    wb_valid = 1'b0;
    flush = 1'b1;
    checks++;
    if (commit_valid !== 1'b0 || commited_wr_register !== 6'd0) begin
      errors++; $display("FAIL flush_cv: cv=%b reg=%0d need 0 0", commit_valid, commited_wr_register);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (empty !== 1'b1 || count !== 5'd0 || alloc_rob_id !== 4'd0 || commit_valid !== 1'b0) begin
      errors++; $display("FAIL flush_after: empty=%b count=%0d id=%0d cv=%b need 1 0 0 0",
                         empty, count, alloc_rob_id, commit_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_out_of_order();
    test_wb_same_cycle();
    test_fill_wrap();
    test_full_commit();
`ifdef ROB_FLUSH_EN
    test_flush();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
